// File: rtl/karatsuba_pkg.sv
// karatsuba_pkg: shared constants, state type and helpers for the Karatsuba GF(2) multiplier tree
package karatsuba_pkg;
  localparam int LEAF_PW  = 13;
  localparam int LEAF_OFF = 7;
  localparam int LEAF_K   = 3;
  typedef enum logic {ACCUM, DONE} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/karatsuba_overlap_accum.sv
// karatsuba_overlap_accum: serial overlap-XOR accumulation of K partial products at index*OFF offsets
module karatsuba_overlap_accum
  import karatsuba_pkg::*;
#(
  parameter int PW  = LEAF_PW,
  parameter int OFF = LEAF_OFF,
  parameter int K   = LEAF_K,
  parameter int OW  = (K - 1) * OFF + PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data
);
  localparam int CW = (clog2(K) < 1) ? 1 : clog2(K);
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_acc;
  logic [OW-1:0] w_placed;
  logic          w_fire;
  logic          w_last;
  assign w_fire   = in_valid && (r_state == ACCUM);
  assign w_last   = (r_cnt == CW'(K - 1));
  assign w_placed = OW'(in_data) << (32'(r_cnt) * OFF);
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_next;
  end
  // leave ACCUM on the last term, leave DONE once the consumer takes the product
  always_comb begin
    w_next = r_state;
    if (r_state == ACCUM) w_next = (w_fire && w_last) ? DONE : ACCUM;
    else                  w_next = out_ready ? ACCUM : DONE;
  end
  // handshake flags and product output
  always_comb begin
    in_ready  = (r_state == ACCUM);
    out_valid = (r_state == DONE);
    out_data  = r_acc;
  end
  // index 0 overwrites the accumulator so no clear cycle is needed between products
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_fire) begin
      r_acc <= ((r_cnt == '0) ? '0 : r_acc) ^ w_placed;
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_karatsuba_overlap_accum.sv
// tb_karatsuba_overlap_accum: randomized self-checking bench against a shift/XOR reference model
module tb_karatsuba_overlap_accum;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [12:0] in_data;
  logic [26:0] out_data;
  logic        k1_valid, k1_ready, k1_ovalid;
  logic [7:0]  k1_data, k1_out;
  logic        k4_valid, k4_ready, k4_ovalid;
  logic [4:0]  k4_data;
  logic [22:0] k4_out;
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] terms [4];
  logic [63:0] held;

  always #5 clk = ~clk;

  karatsuba_overlap_accum u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
  karatsuba_overlap_accum #(.PW(8), .OFF(4), .K(1)) u_k1 (
    .clk(clk), .rst(rst), .in_valid(k1_valid), .in_ready(k1_ready), .in_data(k1_data),
    .out_valid(k1_ovalid), .out_ready(1'b1), .out_data(k1_out)
  );
  karatsuba_overlap_accum #(.PW(5), .OFF(6), .K(4)) u_k4 (
    .clk(clk), .rst(rst), .in_valid(k4_valid), .in_ready(k4_ready), .in_data(k4_data),
    .out_valid(k4_ovalid), .out_ready(1'b1), .out_data(k4_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: the product is the XOR of every term shifted to index*off
  function automatic logic [63:0] ref_prod(input int k, input int off);
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < k; i++) acc ^= terms[i] << (i * off);
    return acc;
  endfunction

  task automatic send(input logic [12:0] d, input int gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_valid", 64'(out_valid), 64'd0);
    chk("rel_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    k1_valid = 1'b0; k1_data = '0; k4_valid = 1'b0; k4_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);

    for (int i = 0; i < 3; i++) begin terms[i] = 64'h1FFF; send(13'h1FFF, 0); end
    chk("ones_latency", 64'(out_valid), 64'd1);
    chk("ones_data", 64'(out_data), 64'h7F0207F);
    chk("ones_model", 64'(out_data), ref_prod(3, 7));
    release_out();

    for (int i = 0; i < 3; i++) begin
      send(13'h0001, 0);
      if (i < 2) repeat (2) begin chk("gap_ready", 64'(in_ready), 64'd1); @(negedge clk); end
    end
    chk("gap_data", 64'(out_data), 64'h0004081);
    release_out();

    for (int i = 0; i < 3; i++) begin terms[i] = 64'($urandom_range(0, 8191)); send(13'(terms[i]), 0); end
    held = ref_prod(3, 7);
    terms[0] = 64'($urandom_range(0, 8191));
    in_valid = 1'b1;
    in_data  = 13'(terms[0]);
    repeat (5) begin
      chk("bp_data", 64'(out_data), held);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ready_after", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin terms[i] = 64'($urandom_range(0, 8191)); send(13'(terms[i]), 0); end
    chk("bp_held_idx0", 64'(out_data), ref_prod(3, 7));
    release_out();

    send(13'h1ABC, 0);
    send(13'h0F0F, 0);
    rst = 1'b1; in_valid = 1'b1; in_data = 13'h1234;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) send(13'h0001, 0);
    chk("rst_mid_data", 64'(out_data), 64'h0004081);
    release_out();

    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(13'h1FFF, 0);
    chk("b2b_a_valid", 64'(out_valid), 64'd1);
    chk("b2b_a_data", 64'(out_data), 64'h7F0207F);
    @(negedge clk);
    chk("b2b_a_pulse", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) send(13'h0001, 0);
    chk("b2b_b_valid", 64'(out_valid), 64'd1);
    chk("b2b_b_data", 64'(out_data), 64'h0004081);
    @(negedge clk);
    chk("b2b_b_pulse", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 3; i++) begin
        terms[i] = 64'($urandom_range(0, 8191));
        send(13'(terms[i]), $urandom_range(0, 2));
      end
      chk("rnd_valid", 64'(out_valid), 64'd1);
      chk("rnd_data", 64'(out_data), ref_prod(3, 7));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rnd_hold", 64'(out_data), ref_prod(3, 7));
      end
      release_out();
    end

    k1_valid = 1'b1; k1_data = 8'hA5;
    @(negedge clk);
    k1_valid = 1'b0;
    chk("k1_valid", 64'(k1_ovalid), 64'd1);
    chk("k1_data", 64'(k1_out), 64'hA5);

    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) begin
        terms[i] = (p == 0) ? 64'h1F : 64'($urandom_range(0, 31));
        k4_valid = 1'b1;
        k4_data  = 5'(terms[i]);
        @(negedge clk);
      end
      k4_valid = 1'b0;
      chk("k4_valid", 64'(k4_ovalid), 64'd1);
      chk("k4_data", 64'(k4_out), ref_prod(4, 6));
      if (p == 0) chk("k4_ones", 64'(k4_out), 64'h7DF7DF);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
